fetch_ifid_unit: RTL

Front end of the 5-stage RISC-V pipeline: owns the program counter, drives the instruction-memory read address, and holds the IF/ID pipeline register. It consumes the pipeline-control outputs of the hazard unit (stall_if, ifid_wren, ifid_flush) and the EX-stage branch redirect. It feeds the decode stage with d_pc/d_insn/d_valid. It also keeps saturating stall and flush event counters for performance debug.

---
 rtl/fetch_ifid_unit_if.sv | 54 +++++
 rtl/fetch_ifid_unit.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/fetch_ifid_unit_if.sv
// Fetch-stage bus bundle: hazard-unit controls, EX redirect, instruction
// memory port, decode-side IF/ID outputs and the debug event counters.
interface fetch_ifid_unit_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  // Pipeline control from the hazard unit
  logic              stall_if;
  logic              ifid_wren;
  logic              ifid_flush;

  // EX-stage redirect
  logic              e_br_taken;
  logic [AWIDTH-1:0] e_br_target;

  // Instruction memory (combinational read of imem_addr)
  logic [AWIDTH-1:0] imem_addr;
  logic [DWIDTH-1:0] imem_data;

  // Fetch-stage observation
  logic [AWIDTH-1:0] f_pc;
  logic [DWIDTH-1:0] f_insn;

  // IF/ID register towards decode
  logic [AWIDTH-1:0] d_pc;
  logic [DWIDTH-1:0] d_insn;
  logic              d_valid;

  // Saturating performance counters
  logic [31:0]       stall_cnt;
  logic [31:0]       flush_cnt;

  // The fetch unit itself
  modport slave (
    input  stall_if, ifid_wren, ifid_flush,
    input  e_br_taken, e_br_target,
    input  imem_data,
    output imem_addr,
    output f_pc, f_insn,
    output d_pc, d_insn, d_valid,
    output stall_cnt, flush_cnt
  );

  // Surrounding pipeline / memory model
  modport master (
    output stall_if, ifid_wren, ifid_flush,
    output e_br_taken, e_br_target,
    output imem_data,
    input  imem_addr,
    input  f_pc, f_insn,
    input  d_pc, d_insn, d_valid,
    input  stall_cnt, flush_cnt
  );
endinterface

// File: rtl/fetch_ifid_unit.sv
// RISC-V 5-stage front end: program counter, instruction-memory address,
// IF/ID pipeline register and saturating stall/flush event counters.
module fetch_ifid_unit #(
  parameter int                AWIDTH   = 32,
  parameter int                DWIDTH   = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = 32'h0100_0000,
  parameter logic [DWIDTH-1:0] NOP_INSN = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              reset,
  fetch_ifid_unit_if.slave  bus
);

  typedef enum logic {
    BOOT,
    RUN
  } state_t;

  state_t            state_q, state_d;
  logic              run_en;

  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [AWIDTH-1:0] d_pc_q, d_pc_d;
  logic [DWIDTH-1:0] d_insn_q, d_insn_d;
  logic              d_valid_q, d_valid_d;
  logic [31:0]       stall_cnt_q, stall_cnt_d;
  logic [31:0]       flush_cnt_q, flush_cnt_d;

  // State register: BOOT after reset, then RUN until the next reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: BOOT lasts exactly one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // FSM output: pipeline controls are honoured only in RUN
  always_comb begin
    run_en = 1'b0;
    case (state_q)
      RUN:     run_en = 1'b1;
      default: run_en = 1'b0;
    endcase
  end

  // PC next state: redirect beats stall, otherwise sequential +4 (wraps)
  always_comb begin
    pc_d = pc_q;
    if (run_en) begin
      if (bus.e_br_taken) begin
        pc_d = {bus.e_br_target[AWIDTH-1:2], 2'b00};
      end else if (!bus.stall_if) begin
        pc_d = pc_q + AWIDTH'(4);
      end
    end
  end

  // PC register
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= BASEADDR;
    end else begin
      pc_q <= pc_d;
    end
  end

  // IF/ID next state: flush beats capture, otherwise hold
  always_comb begin
    d_pc_d    = d_pc_q;
    d_insn_d  = d_insn_q;
    d_valid_d = d_valid_q;
    if (run_en) begin
      if (bus.ifid_flush) begin
        d_pc_d    = pc_q;
        d_insn_d  = NOP_INSN;
        d_valid_d = 1'b0;
      end else if (bus.ifid_wren) begin
        d_pc_d    = pc_q;
        d_insn_d  = bus.imem_data;
        d_valid_d = 1'b1;
      end
    end
  end

  // IF/ID register
  always_ff @(posedge clk) begin
    if (reset) begin
      d_pc_q    <= BASEADDR;
      d_insn_q  <= NOP_INSN;
      d_valid_q <= 1'b0;
    end else begin
      d_pc_q    <= d_pc_d;
      d_insn_q  <= d_insn_d;
      d_valid_q <= d_valid_d;
    end
  end

  // Counter next state: count RUN cycles only, stick at all-ones
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (run_en && bus.stall_if && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (run_en && bus.ifid_flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Outputs: memory address comes straight from the PC register
  assign bus.imem_addr = pc_q;
  assign bus.f_pc      = pc_q;
  assign bus.f_insn    = bus.imem_data;
  assign bus.d_pc      = d_pc_q;
  assign bus.d_insn    = d_insn_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule
